fifo_param: RTL and testbench

//  Parametrised synchronous FIFO with configurable width and depth, occupancy count,

---
 rtl/fifo_param.sv | 135 +++++++++++++
 tb/tb_fifo_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode.
//
// Parameters:
//   WIDTH        data word width
//   ADDR_BITS    log2 of depth (DEPTH = 2**ADDR_BITS)
//   AFULL_LEVEL  almost_full when count >= AFULL_LEVEL
//   AEMPTY_LEVEL almost_empty when count <= AEMPTY_LEVEL
//   FWFT         0: registered read (data one cycle after pop)
//                1: first-word-fall-through (head shown while ready)
//
// Ports:
//   clk, clrn            clock (rising edge), asynchronous active-low reset
//   read, write          pop / push requests
//   data_in              push data
//   clear_flags          synchronous clear of overflow/underflow
//   data_out             read data
//   ready                not empty
//   full                 count == DEPTH
//   almost_full          count >= AFULL_LEVEL
//   almost_empty         count <= AEMPTY_LEVEL
//   count                occupancy 0..DEPTH
//   overflow, underflow  sticky error flags

module fifo_param #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned ADDR_BITS    = 3,
    parameter int unsigned AFULL_LEVEL  = 6,
    parameter int unsigned AEMPTY_LEVEL = 1,
    parameter int unsigned FWFT         = 0
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 read,
    input  logic                 write,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 clear_flags,
    output logic [WIDTH-1:0]     data_out,
    output logic                 ready,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_CNT  = (ADDR_BITS + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_BITS:0] AEMPTY_CNT = (ADDR_BITS + 1)'(AEMPTY_LEVEL);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               rd_acc, wr_acc;
    logic [WIDTH-1:0]   head;

    // Status is derived purely from the registered pointers. The extra pointer
    // bit distinguishes full from empty, so the modular difference is the count.
    always_comb begin
        count        = wr_ptr_q - rd_ptr_q;
        ready        = (count != '0);
        full         = (count == DEPTH_CNT);
        almost_full  = (count >= AFULL_CNT);
        almost_empty = (count <= AEMPTY_CNT);
    end

    // A write into a full FIFO is still accepted when a pop frees a slot the same edge.
    always_comb begin
        rd_acc = read & ready;
        wr_acc = write & (~full | rd_acc);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        // Clear first so a coincident error event wins.
        if (clear_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write && !wr_acc) overflow_d  = 1'b1;
        if (read && !ready)   underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_BITS-1:0]] <= data_in;
    end

    assign head      = mem[rd_ptr_q[ADDR_BITS-1:0]];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    if (FWFT != 0) begin : g_fwft
        // Gated to zero when empty so the output is defined out of reset.
        assign data_out = ready ? head : '0;
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= head;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    logic       clk;
    logic       clrn;
    logic       read;
    logic       write;
    logic [7:0] data_in;
    logic       clear_flags;

    logic [7:0] data_out,     f_data_out;
    logic       ready,        f_ready;
    logic       full,         f_full;
    logic       almost_full,  f_almost_full;
    logic       almost_empty, f_almost_empty;
    logic [3:0] count,        f_count;
    logic       overflow,     f_overflow;
    logic       underflow,    f_underflow;

    int passed = 0;
    int total  = 0;

    fifo_param #(
        .WIDTH(8), .ADDR_BITS(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1), .FWFT(0)
    ) dut (
        .clk(clk), .clrn(clrn), .read(read), .write(write), .data_in(data_in),
        .clear_flags(clear_flags), .data_out(data_out), .ready(ready), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(
        .WIDTH(8), .ADDR_BITS(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .clrn(clrn), .read(read), .write(write), .data_in(data_in),
        .clear_flags(clear_flags), .data_out(f_data_out), .ready(f_ready), .full(f_full),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0; read = 1'b0; write = 1'b0; data_in = 8'h00; clear_flags = 1'b0;
        #12;
        // Reset values
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_dout", 32'(data_out), 0);
        @(negedge clk);
        clrn = 1'b1;
        step();

        // 1: fill e0..e7
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; data_in = 8'(8'he0 + i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_ready", 32'(ready), 1);
            check("fill_aempty", 32'(almost_empty), (i + 1 <= 1) ? 1 : 0);
            check("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check("fill_full", 32'(full), (i + 1 == 8) ? 1 : 0);
            if (i == 0) begin
                check("fwft_head_pre_read", 32'(f_data_out), 32'h00e0);
                check("reg_dout_no_read", 32'(data_out), 0);
            end
        end

        // 2: overflow on write while full, then drain
        data_in = 8'he8;
        step();
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        write = 1'b0; read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_dout", 32'(data_out), 32'(8'he0 + i));
        end
        read = 1'b0;
        check("drain_ready", 32'(ready), 0);
        check("drain_ovf_held", 32'(overflow), 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // 3: simultaneous read+write at full
        write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'he0 + i);
            step();
        end
        check("refill_full", 32'(full), 1);
        read = 1'b1; data_in = 8'he8;
        step();
        check("rw_full_count", 32'(count), 8);
        check("rw_full_ovf", 32'(overflow), 0);
        check("rw_full_dout", 32'(data_out), 32'h00e0);
        write = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("rw_drain_dout", 32'(data_out), 32'(8'he0 + i));
        end
        read = 1'b0;
        check("rw_drain_empty", 32'(ready), 0);

        // 4: underflow and clear interaction
        read = 1'b1;
        step();
        check("unf_flag", 32'(underflow), 1);
        check("unf_count", 32'(count), 0);
        check("unf_dout_hold", 32'(data_out), 32'h00e8);
        read = 1'b0; clear_flags = 1'b1;
        step();
        check("unf_cleared", 32'(underflow), 0);
        read = 1'b1;
        step();
        check("unf_clear_loses", 32'(underflow), 1);
        read = 1'b0;
        step();
        clear_flags = 1'b0;
        check("unf_cleared2", 32'(underflow), 0);
        // Write accepted and read ignored while empty
        write = 1'b1; read = 1'b1; data_in = 8'h5a;
        step();
        check("wr_empty_count", 32'(count), 1);
        check("wr_empty_unf", 32'(underflow), 1);
        write = 1'b0; read = 1'b1; clear_flags = 1'b1;
        step();
        read = 1'b0; clear_flags = 1'b0;
        check("wr_empty_dout", 32'(data_out), 32'h005a);
        check("wr_empty_unf_clr", 32'(underflow), 0);

        // 5: streaming through the pointer wrap
        write = 1'b1; data_in = 8'he0;
        step();
        check("stream_fwft_head0", 32'(f_data_out), 32'h00e0);
        read = 1'b1;
        for (int k = 1; k < 20; k++) begin
            data_in = 8'(8'he0 + k);
            step();
            check("stream_count", 32'(count), 1);
            check("stream_dout", 32'(data_out), 32'(8'he0 + k - 1));
            check("stream_fwft_head", 32'(f_data_out), 32'(8'he0 + k));
        end
        write = 1'b0;
        step();
        read = 1'b0;
        check("stream_last", 32'(data_out), 32'h00f3);
        check("stream_empty", 32'(count), 0);
        check("stream_ovf", 32'(overflow), 0);
        check("stream_unf", 32'(underflow), 0);

        // 6: asynchronous reset mid-cycle
        write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'he0 + i);
            step();
        end
        write = 1'b0;
        check("pre_arst_count", 32'(count), 5);
        #2;
        clrn = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_ready", 32'(ready), 0);
        check("arst_aempty", 32'(almost_empty), 1);
        check("arst_dout", 32'(data_out), 0);
        check("arst_fwft_dout", 32'(f_data_out), 0);
        @(negedge clk);
        clrn = 1'b1;
        write = 1'b1; data_in = 8'ha5;
        step();
        write = 1'b0; read = 1'b1;
        step();
        read = 1'b0;
        check("post_arst_dout", 32'(data_out), 32'h00a5);
        check("post_arst_empty", 32'(count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
